// File: rtl/tiro_uc_if.sv
// -----------------------------------------------------------------------------
// tiro_uc_if
// Bundle between the shot control unit and the shot datapath (slot counter,
// position mux, adder/subtractor, border/collision comparators, position and
// load-flag memories, ship position register).
//
// Status (datapath -> control unit):
//   rco_contador_tiro        slot counter is at 15
//   loaded_tiro              current slot is occupied
//   opcode_tiro[1:0]         direction stored in the current slot
//   x_borda_min_tiro/x_borda_max_tiro/y_borda_min_tiro/y_borda_max_tiro
//                            current slot at x=0 / x=14 / y=0 / y=14
//   colisao_tiro_asteroide   current slot equals the asteroid coordinate
// Control (control unit -> datapath):
//   conta_contador_tiro, reset_contador_tiro, select_mux_pos_tiro[1:0],
//   select_mux_coor_tiro, select_soma_sub_tiro, enable_mem_tiro,
//   enable_load_tiro, new_load_tiro, opcode_registra_tiro[1:0],
//   enable_reg_nave, reset_reg_nave
// Modports: master = control unit side, slave = datapath side.
// -----------------------------------------------------------------------------
interface tiro_uc_if;
    logic       rco_contador_tiro;
    logic       loaded_tiro;
    logic [1:0] opcode_tiro;
    logic       x_borda_min_tiro;
    logic       x_borda_max_tiro;
    logic       y_borda_min_tiro;
    logic       y_borda_max_tiro;
    logic       colisao_tiro_asteroide;

    logic       conta_contador_tiro;
    logic       reset_contador_tiro;
    logic [1:0] select_mux_pos_tiro;
    logic       select_mux_coor_tiro;
    logic       select_soma_sub_tiro;
    logic       enable_mem_tiro;
    logic       enable_load_tiro;
    logic       new_load_tiro;
    logic [1:0] opcode_registra_tiro;
    logic       enable_reg_nave;
    logic       reset_reg_nave;

    modport master (
        input  rco_contador_tiro, loaded_tiro, opcode_tiro,
               x_borda_min_tiro, x_borda_max_tiro,
               y_borda_min_tiro, y_borda_max_tiro,
               colisao_tiro_asteroide,
        output conta_contador_tiro, reset_contador_tiro, select_mux_pos_tiro,
               select_mux_coor_tiro, select_soma_sub_tiro, enable_mem_tiro,
               enable_load_tiro, new_load_tiro, opcode_registra_tiro,
               enable_reg_nave, reset_reg_nave
    );

    modport slave (
        output rco_contador_tiro, loaded_tiro, opcode_tiro,
               x_borda_min_tiro, x_borda_max_tiro,
               y_borda_min_tiro, y_borda_max_tiro,
               colisao_tiro_asteroide,
        input  conta_contador_tiro, reset_contador_tiro, select_mux_pos_tiro,
               select_mux_coor_tiro, select_soma_sub_tiro, enable_mem_tiro,
               enable_load_tiro, new_load_tiro, opcode_registra_tiro,
               enable_reg_nave, reset_reg_nave
    );
endinterface

// File: rtl/tiro_uc.sv
// -----------------------------------------------------------------------------
// tiro_uc
// Control unit for the 16-slot shot datapath. A fire request allocates the
// first free slot and stores ship position and direction there; a game tick
// sweeps all slots, moving each loaded shot one cell, unloading it at the
// border or when it hits the asteroid.
//
// Ports:
//   clock              system clock, rising edge
//   reset              asynchronous, active-low
//   iniciar_movimento  one-cycle game tick pulse
//   disparo            one-cycle fire request pulse
//   opcode_nave[1:0]   ship direction at fire time (00 up,01 right,10 down,11 left)
//   dp                 datapath bundle (tiro_uc_if.master)
//   pronto             one-cycle pulse at end of a tick sweep
//   tiro_descartado    one-cycle pulse when a fire is dropped
//   acerto             one-cycle pulse per shot/asteroid collision
//   db_estado[3:0]     current state code
//
// Optional feature: define TIRO_COOLDOWN_EN to block new fires for
// COOLDOWN_TICKS ticks after each spawn (parameters COOLDOWN_TICKS,
// COOLDOWN_W exist only in that build).
// -----------------------------------------------------------------------------
module tiro_uc
`ifdef TIRO_COOLDOWN_EN
#(
    parameter int COOLDOWN_TICKS = 4,
    parameter int COOLDOWN_W     = 3
)
`endif
(
    input  logic        clock,
    input  logic        reset,
    input  logic        iniciar_movimento,
    input  logic        disparo,
    input  logic [1:0]  opcode_nave,
    tiro_uc_if.master   dp,
    output logic        pronto,
    output logic        tiro_descartado,
    output logic        acerto,
    output logic [3:0]  db_estado
);

    typedef enum logic [3:0] {
        INICIAL   = 4'd0,
        ESPERA    = 4'd1,
        ZERA_TIRO = 4'd2,
        BUSCA     = 4'd3,
        GRAVA     = 4'd4,
        ZERA_MOV  = 4'd5,
        CHECA     = 4'd6,
        REMOVE    = 4'd7,
        ATUALIZA  = 4'd8,
        COLISAO   = 4'd9,
        PROX      = 4'd10,
        FIM       = 4'd11
    } estado_t;

    // Outputs that depend only on the state; registered from the next state
    // so they are glitch-free (the datapath counter clear is asynchronous).
    typedef struct packed {
        logic       reset_contador;
        logic [1:0] select_mux_pos;
        logic       select_mux_coor;
        logic       select_soma_sub;
        logic       enable_mem;
        logic       enable_load;
        logic       new_load;
        logic       enable_reg_nave;
        logic       reset_reg_nave;
        logic       pronto;
    } ctl_t;

    estado_t    estado, prox_estado;
    ctl_t       ctl_r;
    logic       fire_pend, tick_pend;
    logic [1:0] opcode_reg;
    logic       cooldown_ativo;

    // Input-qualified strobes: these must act on the slot currently being
    // looked at, so they are decoded combinationally from state + status.
    logic conta_c, descarte_c, hit_c, drop_cd_c;

    function automatic logic borda_hit(input logic [1:0] op,
                                       input logic xmin, input logic xmax,
                                       input logic ymin, input logic ymax);
        logic h;
        case (op)
            2'b00:   h = ymin;
            2'b01:   h = xmax;
            2'b10:   h = ymax;
            default: h = xmin;
        endcase
        return h;
    endfunction

    function automatic ctl_t moore_ctl(input estado_t s, input logic [1:0] op);
        ctl_t c;
        c = '0;
        case (s)
            INICIAL: begin
                c.reset_contador = 1'b1;
                c.reset_reg_nave = 1'b1;
            end
            ZERA_TIRO: begin
                c.reset_contador  = 1'b1;
                c.enable_reg_nave = 1'b1;
            end
            GRAVA: begin
                c.select_mux_pos = 2'b11;
                c.enable_mem     = 1'b1;
                c.enable_load    = 1'b1;
                c.new_load       = 1'b1;
            end
            ZERA_MOV: c.reset_contador = 1'b1;
            REMOVE:   c.enable_load    = 1'b1;
            ATUALIZA: begin
                // Vertical moves (00, 10) go through y; up (00) and left (11)
                // decrement.
                c.select_mux_coor = ~op[0];
                c.select_soma_sub = ~(op[1] ^ op[0]);
                c.select_mux_pos  = op[0] ? 2'b01 : 2'b10;
                c.enable_mem      = 1'b1;
            end
            FIM:      c.pronto = 1'b1;
            default:  ;
        endcase
        return c;
    endfunction

`ifdef TIRO_COOLDOWN_EN
    logic [COOLDOWN_W-1:0] cooldown;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cooldown <= '0;
        end else if (estado == GRAVA) begin
            cooldown <= COOLDOWN_W'(COOLDOWN_TICKS);
        end else if (iniciar_movimento && (cooldown != '0)) begin
            cooldown <= cooldown - 1'b1;
        end
    end

    assign cooldown_ativo = (cooldown != '0);
`else
    assign cooldown_ativo = 1'b0;
`endif

    always_comb begin
        prox_estado = estado;
        conta_c     = 1'b0;
        descarte_c  = 1'b0;
        hit_c       = 1'b0;
        drop_cd_c   = 1'b0;
        case (estado)
            INICIAL: prox_estado = ESPERA;
            ESPERA: begin
                if (fire_pend) begin
                    if (cooldown_ativo) begin
                        descarte_c = 1'b1;
                        drop_cd_c  = 1'b1;
                    end else begin
                        prox_estado = ZERA_TIRO;
                    end
                end else if (tick_pend) begin
                    prox_estado = ZERA_MOV;
                end
            end
            ZERA_TIRO: prox_estado = BUSCA;
            BUSCA: begin
                if (!dp.loaded_tiro) begin
                    prox_estado = GRAVA;
                end else if (dp.rco_contador_tiro) begin
                    descarte_c  = 1'b1;
                    prox_estado = ESPERA;
                end else begin
                    conta_c = 1'b1;
                end
            end
            GRAVA:    prox_estado = ESPERA;
            ZERA_MOV: prox_estado = CHECA;
            CHECA: begin
                if (!dp.loaded_tiro) begin
                    prox_estado = PROX;
                end else if (borda_hit(dp.opcode_tiro,
                                       dp.x_borda_min_tiro, dp.x_borda_max_tiro,
                                       dp.y_borda_min_tiro, dp.y_borda_max_tiro)) begin
                    prox_estado = REMOVE;
                end else begin
                    prox_estado = ATUALIZA;
                end
            end
            REMOVE:   prox_estado = PROX;
            ATUALIZA: prox_estado = COLISAO;
            COLISAO: begin
                // Position memory reads combinationally, so the comparator
                // already sees the freshly moved shot here.
                hit_c       = dp.colisao_tiro_asteroide;
                prox_estado = PROX;
            end
            PROX: begin
                if (dp.rco_contador_tiro) begin
                    prox_estado = FIM;
                end else begin
                    conta_c     = 1'b1;
                    prox_estado = CHECA;
                end
            end
            FIM:     prox_estado = ESPERA;
            default: prox_estado = INICIAL;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado     <= INICIAL;
            ctl_r      <= moore_ctl(INICIAL, 2'b00);
            fire_pend  <= 1'b0;
            tick_pend  <= 1'b0;
            opcode_reg <= 2'b00;
        end else begin
            estado <= prox_estado;
            // The slot counter does not move between CHECA and ATUALIZA, so
            // the opcode seen now is the one the adder setup needs.
            ctl_r  <= moore_ctl(prox_estado, dp.opcode_tiro);
            // A new pulse wins over the clear so it is never lost on the
            // cycle its predecessor is being consumed.
            fire_pend <= disparo |
                         (fire_pend & ~((estado == ZERA_TIRO) | drop_cd_c));
            tick_pend <= iniciar_movimento |
                         (tick_pend & ~(estado == ZERA_MOV));
            if (estado == ZERA_TIRO) begin
                opcode_reg <= opcode_nave;
            end
        end
    end

    assign dp.conta_contador_tiro  = conta_c;
    assign dp.reset_contador_tiro  = ctl_r.reset_contador;
    assign dp.select_mux_pos_tiro  = ctl_r.select_mux_pos;
    assign dp.select_mux_coor_tiro = ctl_r.select_mux_coor;
    assign dp.select_soma_sub_tiro = ctl_r.select_soma_sub;
    assign dp.enable_mem_tiro      = ctl_r.enable_mem;
    assign dp.enable_load_tiro     = ctl_r.enable_load | hit_c;
    assign dp.new_load_tiro        = ctl_r.new_load;
    assign dp.opcode_registra_tiro = opcode_reg;
    assign dp.enable_reg_nave      = ctl_r.enable_reg_nave;
    assign dp.reset_reg_nave       = ctl_r.reset_reg_nave;

    assign pronto          = ctl_r.pronto;
    assign tiro_descartado = descarte_c;
    assign acerto          = hit_c;
    assign db_estado       = estado;

endmodule

// File: doc/tiro_uc.md
Name: tiro_uc

Overview:
- Control unit for the shot datapath: the 16-slot shot memory with its slot counter, position mux, adder/subtractor, border/collision comparators and load-flag memory.
- On a fire request it allocates the first free slot and writes the ship position and direction into it.
- On each game tick it walks all 16 slots. Each loaded shot is moved one cell, unloaded at the border or on an asteroid hit.
- Sits between the game top-level FSM (tick, fire, ship opcode) and the shot datapath. All datapath control inputs are driven from here.

Parameters:
- COOLDOWN_TICKS, 4, number of ticks a new fire is blocked after a spawn (only with TIRO_COOLDOWN_EN).
- COOLDOWN_W, 3, width of the cooldown counter; must hold COOLDOWN_TICKS.

Ports:
- clock  in  1  system clock; all flops on rising edge.
- reset  in  1  asynchronous, active-low reset.
- iniciar_movimento  in  1  one-cycle game tick pulse.
- disparo  in  1  one-cycle fire request pulse.
- opcode_nave  in  2  ship direction at fire time: 00 up, 01 right, 10 down, 11 left.
- rco_contador_tiro  in  1  slot counter at 15.
- loaded_tiro  in  1  current slot is occupied.
- opcode_tiro  in  2  direction stored in current slot.
- x_borda_min_tiro, x_borda_max_tiro, y_borda_min_tiro, y_borda_max_tiro  in  1 each  current slot at x=0, x=14, y=0, y=14.
- colisao_tiro_asteroide  in  1  current slot equals asteroid coordinate.
- conta_contador_tiro  out  1  advance slot counter.
- reset_contador_tiro  out  1  clear slot counter to 0 (datapath clear is async; hold one full cycle).
- select_mux_pos_tiro  out  2  00 hold, 01 {soma,y,op}, 10 {x,soma,op}, 11 {nave_x,nave_y,opcode_registra}.
- select_mux_coor_tiro  out  1  0 selects x, 1 selects y into the adder.
- select_soma_sub_tiro  out  1  0 = +1, 1 = -1.
- enable_mem_tiro  out  1  write position memory at current slot.
- enable_load_tiro  out  1  write load-flag memory at current slot.
- new_load_tiro  out  1  value written to the load flag.
- opcode_registra_tiro  out  2  direction for a new shot (latched opcode_nave).
- enable_reg_nave, reset_reg_nave  out  1 each  ship position register control.
- pronto  out  1  one-cycle pulse at end of a tick sweep.
- tiro_descartado  out  1  one-cycle pulse: fire dropped (all 16 slots loaded, or cooldown active).
- acerto  out  1  one-cycle pulse per shot/asteroid collision.
- db_estado  out  4  current state code.

Behaviour:
- Moore FSM, one-hot or binary encoding (implementer's choice); db_estado codes are listed in state order below, starting at 0.
- States: INICIAL, ESPERA, ZERA_TIRO, BUSCA, GRAVA, ZERA_MOV, CHECA, REMOVE, ATUALIZA, COLISAO, PROX, FIM.
- reset low forces INICIAL.
  - In INICIAL: reset_contador_tiro=1, reset_reg_nave=1, all other outputs 0.
  - INICIAL always goes to ESPERA.
  - Any output not asserted in a state is 0.
- ESPERA transitions:
  - Fire pending → ZERA_TIRO.
  - Else tick pending → ZERA_MOV.
  - Fire has priority over tick.
- Pending flags:
  - disparo and iniciar_movimento each set a 1-deep pending flag in any state.
  - A flag clears when its sequence starts: ZERA_TIRO for fire, ZERA_MOV for tick.
  - An extra pulse while a flag is already set is lost.
- ZERA_TIRO:
  - Asserts reset_contador_tiro=1 and enable_reg_nave=1.
  - Latches opcode_nave into opcode_registra_tiro, which holds until the next fire.
  - Goes to BUSCA.
- BUSCA:
  - loaded_tiro=0 → GRAVA.
  - Else rco=1 → pulse tiro_descartado, go to ESPERA.
  - Else conta=1, stay in BUSCA.
- GRAVA:
  - Asserts select_mux_pos=11, enable_mem_tiro=1, enable_load_tiro=1, new_load_tiro=1.
  - Goes to ESPERA.
- ZERA_MOV: reset_contador_tiro=1, then CHECA.
- CHECA:
  - loaded_tiro=0 → PROX.
  - Border hit in the shot's direction → REMOVE. Hit means: opcode 00 and y_min, 01 and x_max, 10 and y_max, 11 and x_min.
  - Otherwise → ATUALIZA.
- REMOVE: enable_load_tiro=1, new_load_tiro=0, then PROX.
- ATUALIZA:
  - Adder setup per opcode: 00 coor=1, sub=1; 01 coor=0, sub=0; 10 coor=1, sub=0; 11 coor=0, sub=1.
  - select_mux_pos is 01 when coor=0, 10 when coor=1.
  - Asserts enable_mem_tiro=1, then COLISAO.
- COLISAO:
  - Memory read is combinational, so the comparators see the updated position.
  - colisao=1 → enable_load_tiro=1, new_load_tiro=0, acerto=1.
  - Then PROX.
- PROX: rco=1 → FIM; else conta=1 → CHECA.
- FIM: pronto=1, then ESPERA.
- Arithmetic: never steps outside 0..14 because border checks precede movement; wrap-around is never generated.
- Reset mid-sweep: the sweep is abandoned and pending flags clear. Slot contents are unchanged; memories are not reset by this block.

Optional Feature:
- Macro TIRO_COOLDOWN_EN.
- When defined:
  - A COOLDOWN_W-bit counter loads COOLDOWN_TICKS in GRAVA and decrements on each iniciar_movimento pulse while nonzero.
  - A fire reaching ESPERA with counter≠0 pulses tiro_descartado and returns to ESPERA without touching the datapath.
  - The counter resets to 0.
- When undefined: no counter; every fire is served subject only to slot availability.

Test Plan:
- Reset low for 3 cycles, release → INICIAL for one cycle with reset_contador_tiro=1 and reset_reg_nave=1, then ESPERA with all outputs 0.
- Empty memory, disparo with opcode_nave=01 → ZERA_TIRO, BUSCA, GRAVA; slot 0 written with select_mux_pos=11, new_load=1, opcode_registra_tiro=01.
- Slot 0 loaded at x=7,y=7,op=01, tick → slot 0 becomes x=8 after one sweep; pronto pulses exactly once after 16 slot visits.
- Shot at x=14, op=01, tick → REMOVE, load flag cleared, no memory write; shot at y=0, op=00 → removed likewise.
- Shot at x=4,y=5, op=11, asteroid at 3,5 → ATUALIZA writes x=3; COLISAO asserts acerto=1 and clears the load flag.
- All 16 slots loaded, disparo → tiro_descartado after 16 BUSCA cycles. disparo and tick in the same cycle → fire served first, then sweep. With TIRO_COOLDOWN_EN: second fire within 4 ticks → tiro_descartado.
